// File: rtl/spkr_pkg.sv
// Shared types and constants for the multi-channel speaker driver.
package spkr_pkg;

    // Soft-mute gain controller states.
    typedef enum logic [1:0] {
        MUTED   = 2'd0,
        RAMP_UP = 2'd1,
        UNITY   = 2'd2,
        RAMP_DN = 2'd3
    } ramp_state_t;

    // Gain is 0..256 unsigned; 256 means unity.
    localparam int                GAIN_W     = 9;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;
    localparam logic [GAIN_W-1:0] GAIN_STEP  = 9'd1;

endpackage

// File: rtl/pdm_mod.sv
// First-order PDM modulator: the carry out of an accumulator fed with an
// offset-binary duty value becomes the output bitstream.
module pdm_mod #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] duty,
    output logic         pdm,
    output logic         pdm_n
);

    logic [W-1:0] acc;
    logic [W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, duty};

    // Accumulate duty; the carry is the pulse density.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            pdm   <= 1'b0;
            pdm_n <= 1'b1;
        end else begin
            acc   <= sum[W-1:0];
            pdm   <= sum[W];
            pdm_n <= ~sum[W];
        end
    end

endmodule

// File: rtl/spkr_drv_mc.sv
// Multi-channel PDM speaker driver with shared soft mute/unmute gain ramp.
// Per channel: capture -> scale by gain -> offset-binary duty -> PDM.
module spkr_drv_mc
    import spkr_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int W        = 16,
    parameter int RAMP_DIV = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vld,
    input  logic [NUM_CH*W-1:0] chnl_in,
    input  logic                mute,
    output logic [NUM_CH-1:0]   pdm,
    output logic [NUM_CH-1:0]   pdm_n,
    output logic                muted,
    output logic                ramping
);

    localparam int           CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [W-1:0] MID   = {1'b1, {(W-1){1'b0}}};

    ramp_state_t       state, state_nxt;
    logic [GAIN_W-1:0] gain, gain_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              tick;
    logic signed [GAIN_W:0] gain_s;

    assign muted   = (state == MUTED);
    assign ramping = (state == RAMP_UP) || (state == RAMP_DN);
    assign tick    = ramping && (cnt == CNT_W'(RAMP_DIV - 1));
    assign gain_s  = $signed({1'b0, gain});

    // Next state and gain; a direction change has priority over a tick.
    // NOTE: state_nxt/gain_nxt get defaults first so no path leaves them unassigned (no latch).
    always_comb begin
        state_nxt = state;
        gain_nxt  = gain;
        case (state)
            MUTED: begin
                gain_nxt = '0;
                if (!mute) state_nxt = RAMP_UP;
            end
            RAMP_UP: begin
                if (mute) begin
                    state_nxt = RAMP_DN;
                end else if (tick) begin
                    if (gain >= (GAIN_UNITY - GAIN_STEP)) begin
                        gain_nxt  = GAIN_UNITY;
                        state_nxt = UNITY;
                    end else begin
                        gain_nxt = gain + GAIN_STEP;
                    end
                end
            end
            UNITY: begin
                gain_nxt = GAIN_UNITY;
                if (mute) state_nxt = RAMP_DN;
            end
            RAMP_DN: begin
                if (!mute) begin
                    state_nxt = RAMP_UP;
                end else if (tick) begin
                    if (gain <= GAIN_STEP) begin
                        gain_nxt  = '0;
                        state_nxt = MUTED;
                    end else begin
                        gain_nxt = gain - GAIN_STEP;
                    end
                end
            end
            default: begin
                gain_nxt  = '0;
                state_nxt = MUTED;
            end
        endcase
    end

    // State and gain registers; reset lands in MUTED at zero gain so release only ramps up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MUTED;
            gain  <= '0;
        end else begin
            state <= state_nxt;
            gain  <= gain_nxt;
        end
    end

    // Ramp prescaler: restarts on every state entry, runs only while ramping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (ramping) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : gen_ch
        logic signed [W-1:0]        sample;
        logic signed [W-1:0]        scaled;
        logic        [W-1:0]        duty;
        logic signed [W+GAIN_W-1:0] prod;

        // Full-precision product; |sample*256| always fits so truncation after >>>8 is exact.
        assign prod = sample * gain_s;

        // Capture, scale and offset-binary pipeline for this channel.
        // NOTE: datapath registers are reset too, so the output is silent midscale straight out of reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sample <= '0;
                scaled <= '0;
                duty   <= MID;
            end else begin
                if (vld) sample <= chnl_in[k*W +: W];
                scaled <= W'(prod >>> 8);
                duty   <= scaled ^ MID;
            end
        end

        pdm_mod #(.W(W)) u_pdm (
            .clk   (clk),
            .rst_n (rst_n),
            .duty  (duty),
            .pdm   (pdm[k]),
            .pdm_n (pdm_n[k])
        );
    end

endmodule

// File: tb/tb_spkr_drv_mc.sv
// Self-checking bench for spkr_drv_mc: directed ramp/reset sequences,
// a table of steady-state duty vectors, and a randomized run against a
// behavioural gain/PDM model.
module tb_spkr_drv_mc;

    localparam int NUM_CH   = 2;
    localparam int W        = 16;
    localparam int RAMP_DIV = 4;
    localparam int MID      = 1 << (W - 1);
    localparam int FULL     = 1 << W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                vld = 1'b0;
    logic                mute = 1'b1;
    logic [NUM_CH*W-1:0] chnl_in = '0;
    logic [NUM_CH-1:0]   pdm, pdm_n;
    logic                muted, ramping;

    int total = 0;
    int bad   = 0;

    spkr_drv_mc #(.NUM_CH(NUM_CH), .W(W), .RAMP_DIV(RAMP_DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld     (vld),
        .chnl_in (chnl_in),
        .mute    (mute),
        .pdm     (pdm),
        .pdm_n   (pdm_n),
        .muted   (muted),
        .ramping (ramping)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Load both channels, then wait until pdm reflects the new duty.
    task automatic load(input logic [W-1:0] c0, input logic [W-1:0] c1);
        chnl_in = {c1, c0};
        vld = 1'b1;
        step(1);
        vld = 1'b0;
        step(3);
    endtask

    // Count ones per channel over n cycles; also report any pdm_n mismatch.
    task automatic count_ones(input int n, output int o0, output int o1, output int cmp_err);
        o0 = 0; o1 = 0; cmp_err = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            o0 += int'(pdm[0]);
            o1 += int'(pdm[1]);
            if (pdm_n !== ~pdm) cmp_err++;
        end
    endtask

    // Behavioural model helpers.
    function automatic int scale(input int s, input int g);
        int p;
        p = s * g;
        return p >>> 8;
    endfunction

    function automatic int to_duty(input int scaled_v);
        return (scaled_v & (FULL - 1)) ^ MID;
    endfunction

    typedef struct {
        logic [W-1:0] c0;
        logic [W-1:0] c1;
        int           d0;
        int           d1;
    } vec_t;

    typedef struct {
        int gain;
        int smp [NUM_CH];
    } snap_t;

    initial begin
        vec_t  vecs [5];
        int    o0, o1, cerr, flag, g, g_prev;
        // random-phase model state
        snap_t q [$];
        snap_t cur, old;
        int    acc [NUM_CH];
        int    duty [NUM_CH];
        int    m_gain, m_phase, hold;
        bit    m_busy, m_up, req_up;
        logic [NUM_CH-1:0] e_pdm;

        vecs[0] = '{16'h0000, 16'h0000, 'h8000, 'h8000};
        vecs[1] = '{16'h7FFF, 16'h8000, 'hFFFF, 'h0000};
        vecs[2] = '{16'h4000, 16'hC000, 'hC000, 'h4000};
        vecs[3] = '{16'h0001, 16'hFFFF, 'h8001, 'h7FFF};
        vecs[4] = '{16'h2000, 16'hE000, 'hA000, 'h6000};

        // ---- Reset values ----
        step(2);
        check("rst_muted", muted, 1);
        check("rst_ramping", ramping, 0);
        check("rst_pdm", pdm, 0);
        check("rst_pdm_n", pdm_n, 2'b11);
        check("rst_gain", dut.gain, 0);
        check("rst_duty", dut.gen_ch[0].duty, MID);
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        check("hold_muted", muted, 1);

        // ---- Full unmute ramp, with a gain=128 scaling probe ----
        mute = 1'b0;
        flag = 0;
        for (int i = 1; i <= 1025; i++) begin
            step(1);
            if (muted !== 1'b0) flag++;
            if (i == 1) check("ramp_start", ramping, 1);
            if (i == 513) begin
                check("gain_mid", dut.gain, 128);
                chnl_in = {16'h0000, 16'h4000};
                vld = 1'b1;
            end
            if (i == 514) vld = 1'b0;
            if (i == 517) check("duty_g128", dut.gen_ch[0].duty, 'hA000);
            if (i == 1024) check("ramp_1024", ramping, 1);
        end
        check("muted_during_ramp", flag, 0);
        check("unity_ramping", ramping, 0);
        check("unity_gain", dut.gain, 256);
        check("unity_muted", muted, 0);

        // ---- Table-driven steady-state duty at unity gain ----
        foreach (vecs[v]) begin
            load(vecs[v].c0, vecs[v].c1);
            count_ones(1024, o0, o1, cerr);
            check_rng($sformatf("vec%0d_ch0", v), o0, vecs[v].d0 >> 6, (vecs[v].d0 >> 6) + 1);
            check_rng($sformatf("vec%0d_ch1", v), o1, vecs[v].d1 >> 6, (vecs[v].d1 >> 6) + 1);
            check($sformatf("vec%0d_pdm_n", v), cerr, 0);
        end

        // ---- Zero input: strict alternation ----
        load(16'h0000, 16'h0000);
        flag = 0;
        o0 = 0;
        step(1);
        for (int i = 0; i < 256; i++) begin
            logic p_prev;
            p_prev = pdm[0];
            o0 += int'(pdm[0]);
            step(1);
            if (pdm[0] === p_prev) flag++;
        end
        check("alt_toggle", flag, 0);
        check("alt_ones", o0, 128);

        // ---- Full-scale inputs over one full accumulator period ----
        load(16'h7FFF, 16'h8000);
        count_ones(65536, o0, o1, cerr);
        check("fs_pos_ones", o0, 65535);
        check("fs_neg_ones", o1, 0);
        check("fs_pdm_n", cerr, 0);

        // ---- Partial mute then unmute: smooth reversal ----
        mute = 1'b1;
        flag = 0;
        g_prev = 256;
        for (int i = 0; i < 401; i++) begin
            step(1);
            g = int'(dut.gain);
            if (g > g_prev || g_prev - g > 1) flag++;
            g_prev = g;
        end
        check("dn_monotonic", flag, 0);
        check("dn_gain", dut.gain, 156);
        check("dn_ramping", ramping, 1);
        mute = 1'b0;
        flag = 0;
        for (int i = 0; i < 401; i++) begin
            step(1);
            g = int'(dut.gain);
            if (g < g_prev || g - g_prev > 1) flag++;
            if (i == 0) check("rev_no_step", g, 156);
            if (i == 399) check("up_not_done", ramping, 1);
            g_prev = g;
        end
        check("up_monotonic", flag, 0);
        check("up_gain", dut.gain, 256);
        check("up_ramping", ramping, 0);

        // ---- Asynchronous reset mid ramp-down ----
        mute = 1'b1;
        step(50);
        #2 rst_n = 1'b0;
        #1;
        check("arst_muted", muted, 1);
        check("arst_ramping", ramping, 0);
        check("arst_pdm", pdm, 0);
        check("arst_pdm_n", pdm_n, 2'b11);
        check("arst_gain", dut.gain, 0);
        @(negedge clk);
        @(negedge clk);
        mute = 1'b0;
        rst_n = 1'b1;
        step(1);
        check("arst_rel_ramping", ramping, 1);
        check("arst_rel_gain", dut.gain, 0);
        step(4);
        check("arst_first_step", dut.gain, 1);

        // ---- Randomized run against the behavioural model ----
        step(1);
        rst_n = 1'b0;
        step(2);
        cur.gain = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            cur.smp[c] = 0;
            acc[c] = 0;
            duty[c] = MID;
        end
        q.delete();
        q.push_back(cur);
        q.push_back(cur);
        m_gain = 0; m_phase = 0; m_busy = 0; m_up = 0;
        hold = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 4000; t++) begin
            if (hold == 0) begin
                mute = 1'($urandom_range(0, 1));
                hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(50, 1200));
            end
            hold--;
            vld = ($urandom_range(0, 3) == 0);
            chnl_in = {16'($urandom), 16'($urandom)};
            step(1);

            // PDM output from the duty that was in place before this edge.
            old = q.pop_front();
            for (int c = 0; c < NUM_CH; c++) begin
                e_pdm[c] = (acc[c] + duty[c]) >= FULL;
                acc[c]   = (acc[c] + duty[c]) % FULL;
                duty[c]  = to_duty(scale(old.smp[c], old.gain));
            end

            // Gain: ramp toward 0 or 256 one step per RAMP_DIV clocks; reversal restarts timing.
            req_up = !mute;
            if (!m_busy) begin
                if (req_up && m_gain != 256) begin
                    m_busy = 1; m_up = 1; m_phase = 0;
                end else if (!req_up && m_gain != 0) begin
                    m_busy = 1; m_up = 0; m_phase = 0;
                end
            end else if (req_up != m_up) begin
                m_up = req_up;
                m_phase = 0;
            end else begin
                m_phase++;
                if (m_phase == RAMP_DIV) begin
                    m_phase = 0;
                    if (m_up) m_gain = (m_gain + 1 > 256) ? 256 : m_gain + 1;
                    else      m_gain = (m_gain - 1 < 0) ? 0 : m_gain - 1;
                    if (m_gain == (m_up ? 256 : 0)) m_busy = 0;
                end
            end

            if (vld) for (int c = 0; c < NUM_CH; c++) cur.smp[c] = int'($signed(chnl_in[c*W +: W]));
            cur.gain = m_gain;
            q.push_back(cur);

            check($sformatf("rand_t%0d", t), {muted, ramping, pdm, pdm_n},
                  {(!m_busy && m_gain == 0), m_busy, e_pdm, ~e_pdm});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
